// File: rtl/sram_arbiter_n_if.sv
// rtl/sram_arbiter_n_if.sv - master-side request bus shared by all masters of sram_arbiter_n
interface sram_arbiter_n_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address;
  logic [NUM_MASTERS*BE_WIDTH-1:0]   m_byteenable;
  logic [NUM_MASTERS-1:0]            m_read;
  logic [NUM_MASTERS-1:0]            m_write;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wrdata;
  logic [DATA_WIDTH-1:0]             m_rddata;
  logic [NUM_MASTERS-1:0]            m_stall;

  modport master (
    output m_address, m_byteenable, m_read, m_write, m_wrdata,
    input  m_rddata, m_stall
  );

  modport slave (
    input  m_address, m_byteenable, m_read, m_write, m_wrdata,
    output m_rddata, m_stall
  );
endinterface

// File: rtl/sram_arbiter_n.sv
// rtl/sram_arbiter_n.sv - round-robin N-master arbiter and controller for one async SRAM bank
module sram_arbiter_n #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sram_arbiter_n_if.slave         bus,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH/8-1:0] sram_be_n,
  output logic                    sram_ce_n,
  output logic                    sram_oe_n,
  output logic                    sram_we_n,
  output logic [DATA_WIDTH-1:0]   sram_data_o,
  output logic                    sram_data_oe,
  input  logic [DATA_WIDTH-1:0]   sram_data_i
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int GW       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WRHOLD = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         last_grant_q, last_grant_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BE_WIDTH-1:0]   be_n_q, be_n_d;
  logic                  ce_n_q, ce_n_d;
  logic                  oe_n_q, oe_n_d;
  logic                  we_n_q, we_n_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  doe_q, doe_d;
  logic [DATA_WIDTH-1:0] rddata_q, rddata_d;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] stall;
  logic [GW-1:0]          sel;
  logic                   any_req;

  assign req = bus.m_read | bus.m_write;

  // Rotating priority: search starts just after the last master served.
  always_comb begin
    sel     = '0;
    any_req = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      int idx;
      idx = (int'(last_grant_q) + k) % NUM_MASTERS;
      if (!any_req && req[idx]) begin
        sel     = GW'(idx);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      stall[i] = req[i] & ~((state_q == S_DONE) && (grant_q == GW'(i)));
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    be_n_d       = be_n_q;
    ce_n_d       = ce_n_q;
    oe_n_d       = oe_n_q;
    we_n_d       = we_n_q;
    data_d       = data_q;
    doe_d        = doe_q;
    rddata_d     = rddata_q;
    case (state_q)
      S_IDLE: begin
        ce_n_d = 1'b1;
        oe_n_d = 1'b1;
        we_n_d = 1'b1;
        be_n_d = '1;
        doe_d  = 1'b0;
        if (any_req) begin
          grant_d      = sel;
          last_grant_d = sel;
          wr_d         = bus.m_write[sel];
          addr_d       = bus.m_address[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
          be_n_d       = ~bus.m_byteenable[int'(sel)*BE_WIDTH +: BE_WIDTH];
          data_d       = bus.m_wrdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
          ce_n_d       = 1'b0;
          oe_n_d       = bus.m_write[sel];
          we_n_d       = ~bus.m_write[sel];
          doe_d        = bus.m_write[sel];
          cnt_d        = CNT_INIT;
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (wr_q) begin
          // Raise we_n one cycle ahead of ce_n so data/address hold past the write strobe.
          we_n_d  = 1'b1;
          state_d = S_WRHOLD;
        end else begin
          rddata_d = sram_data_i;
          ce_n_d   = 1'b1;
          oe_n_d   = 1'b1;
          be_n_d   = '1;
          state_d  = S_DONE;
        end
      end
      S_WRHOLD: begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        be_n_d  = '1;
        doe_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        be_n_d  = '1;
        doe_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_MASTERS - 1);
      cnt_q        <= 4'd0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      be_n_q       <= '1;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      data_q       <= '0;
      doe_q        <= 1'b0;
      rddata_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      be_n_q       <= be_n_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      data_q       <= data_d;
      doe_q        <= doe_d;
      rddata_q     <= rddata_d;
    end
  end

  assign bus.m_stall   = stall;
  assign bus.m_rddata  = rddata_q;
  assign sram_addr     = addr_q;
  assign sram_be_n     = be_n_q;
  assign sram_ce_n     = ce_n_q;
  assign sram_oe_n     = oe_n_q;
  assign sram_we_n     = we_n_q;
  assign sram_data_o   = data_q;
  assign sram_data_oe  = doe_q;
endmodule
